// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 issue stage: ALU select codes and the
// packed command layout {op, a, b, acc} stored in the command FIFO.
package alu32_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_ADDC = 3'd4;
    localparam logic [OP_W-1:0] OP_SRA  = 3'd5;
    localparam logic [OP_W-1:0] OP_SL   = 3'd6;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd7;

    // Packed command width for a given operand width: op + a + b + acc flag.
    function automatic int cmd_width(input int w);
        return OP_W + 2 * w + 1;
    endfunction

endpackage

// File: rtl/alu32_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO holding packed ALU commands. Push is ignored
// when full and pop is ignored when empty.
module alu32_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 68
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CNTW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu32_issue.sv
// Issue stage for alu32: queues commands, drives the ALU from the FIFO head,
// captures the result on a valid/ready port and keeps a chaining accumulator.
module alu32_issue
    import alu32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    input  logic             acc_clear,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc_value
);

    localparam int CW   = cmd_width(WIDTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [CW-1:0]    w_push_data;
    logic [CW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNTW-1:0]  w_count;
    logic             w_issue;
    logic [OP_W-1:0]  w_head_op;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic             w_head_acc;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [WIDTH-1:0] r_acc;

    assign w_push_data = {cmd_op, cmd_a, cmd_b, cmd_acc};
    assign w_head_op   = w_head[CW-1 -: OP_W];
    assign w_head_a    = w_head[CW-OP_W-1 -: WIDTH];
    assign w_head_b    = w_head[WIDTH:1];
    assign w_head_acc  = w_head[0];

    // cmd_ready looks only at registered occupancy, so a full FIFO refuses a
    // push even on a cycle that also pops.
    assign cmd_ready = !w_full && !rst;
    assign w_issue   = !w_empty && (!r_res_valid || res_ready);

    alu32_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid && cmd_ready),
        .i_data  (w_push_data),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        alu_A      = '0;
        alu_B      = '0;
        alu_select = '0;
        if (!w_empty) begin
            alu_A      = w_head_acc ? r_acc : w_head_a;
            alu_B      = w_head_b;
            alu_select = w_head_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_acc       <= '0;
        end else begin
            if (w_issue) begin
                r_res_valid <= 1'b1;
                r_res_data  <= alu_out;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
            // Clear beats a coincident issue; res_data still captures the result.
            if (acc_clear)    r_acc <= '0;
            else if (w_issue) r_acc <= alu_out;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_zero  = (r_res_data == '0);
    assign acc_value = r_acc;

    a_count_bound: assert property (@(posedge clk) w_count <= CNTW'(DEPTH));

endmodule

// File: tb/tb_alu32_issue.sv
// Self-checking bench for alu32_issue with a behavioural alu32 stand-in and a
// queue-based reference model of the issue stage.
module tb_alu32_issue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_acc;
    logic             acc_clear;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [2:0]       alu_select;
    logic [WIDTH-1:0] alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [WIDTH-1:0] acc_value;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        acc;
    } cmd_t;

    cmd_t        mq[$];
    logic        m_rv;
    logic [31:0] m_rd;
    logic [31:0] m_acc;
    logic        m_iss;

    always #5 clk = ~clk;

    alu32_issue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
        .acc_clear(acc_clear), .alu_A(alu_A), .alu_B(alu_B),
        .alu_select(alu_select), .alu_out(alu_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
        .acc_value(acc_value)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return a + b + 32'd1;
            3'd5:    return $unsigned($signed(a) >>> b[4:0]);
            3'd6:    return a << b[4:0];
            default: return ~(a | b);
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_A, alu_B, alu_select);

    // One clock edge; the model advances from the inputs held across the edge.
    task automatic tick();
        bit          push;
        bit          iss;
        cmd_t        h;
        logic [31:0] r;
        push = cmd_valid && !rst && (mq.size() < DEPTH);
        iss  = !rst && (mq.size() > 0) && (!m_rv || res_ready);
        @(posedge clk);
        #1;
        m_iss = iss;
        if (rst) begin
            mq.delete();
            m_rv = 1'b0; m_rd = '0; m_acc = '0;
        end else begin
            r = '0;
            if (iss) begin
                h = mq.pop_front();
                r = alu_fn(h.acc ? m_acc : h.a, h.b, h.op);
                m_rv = 1'b1; m_rd = r;
            end else if (res_ready) begin
                m_rv = 1'b0;
            end
            if (push) mq.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, acc: cmd_acc});
            if (acc_clear) m_acc = '0;
            else if (iss) m_acc = r;
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit acc);
        cmd_valid = v; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(0, 0, 0, 0, 0); acc_clear = 0; res_ready = 0;
        tick(); tick();
        n_chk += 5;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        if (res_data !== '0)    begin n_fail++; $display("FAIL reset_data got=%h want=0", res_data); end
        if (res_zero !== 1'b1)  begin n_fail++; $display("FAIL reset_zero got=%b want=1", res_zero); end
        if (acc_value !== '0)   begin n_fail++; $display("FAIL reset_acc got=%h want=0", acc_value); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst got=%b want=0", cmd_ready); end
        rst = 1'b0; #1;
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b want=1", cmd_ready); end
    endtask

    task automatic test_reset_midstream();
        res_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd2, 32'h10 + i, 32'h3, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_chk += 2;
        if (res_valid !== 1'b1)  begin n_fail++; $display("FAIL mid_pre_valid got=%b want=1", res_valid); end
        if (acc_value !== 32'h13) begin n_fail++; $display("FAIL mid_pre_acc got=%h want=13", acc_value); end
        rst = 1; tick(); rst = 0; #1;
        n_chk += 5;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b want=0", res_valid); end
        if (acc_value !== '0)   begin n_fail++; $display("FAIL mid_acc got=%h want=0", acc_value); end
        if (res_zero !== 1'b1)  begin n_fail++; $display("FAIL mid_zero got=%b want=1", res_zero); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b want=1", cmd_ready); end
        if ({alu_select, alu_A, alu_B} !== '0) begin
            n_fail++; $display("FAIL mid_alu_drive got=%h/%h/%h want=0", alu_select, alu_A, alu_B);
        end
    endtask

    task automatic test_single();
        res_ready = 1;
        drive(1, 3'd0, 32'h0000F0F0, 32'h0000FF00, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_chk += 2;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b want=0", res_valid); end
        if (alu_select !== 3'd0 || alu_A !== 32'h0000F0F0 || alu_B !== 32'h0000FF00) begin
            n_fail++; $display("FAIL single_drive got=%h/%h/%h want=0/0000f0f0/0000ff00", alu_select, alu_A, alu_B);
        end
        tick();
        n_chk += 3;
        if (res_valid !== 1'b1)         begin n_fail++; $display("FAIL single_valid got=%b want=1", res_valid); end
        if (res_data !== 32'h0000F000) begin n_fail++; $display("FAIL single_data got=%h want=0000f000", res_data); end
        if (res_zero !== 1'b0)          begin n_fail++; $display("FAIL single_zero got=%b want=0", res_zero); end
        tick();
        n_chk++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b want=0", res_valid); end
    endtask

    task automatic test_chain();
        logic [31:0] exp_v [3];
        exp_v[0] = 32'd12; exp_v[1] = 32'd15; exp_v[2] = 32'd0;
        res_ready = 1;
        drive(1, 3'd2, 32'd5, 32'd7, 0);          tick();
        drive(1, 3'd2, 32'hDEAD, 32'd3, 1);       tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1, 3'd2, 32'hBEEF, 32'hFFFFFFF1, 1);
            else        drive(0, 0, 0, 0, 0);
            if (i > 0 || 1) begin end
            n_chk += 2;
            if (res_valid !== 1'b1 || res_data !== exp_v[i]) begin
                n_fail++; $display("FAIL chain_%0d got=%b/%0d want=1/%0d", i, res_valid, res_data, exp_v[i]);
            end
            if (acc_value !== exp_v[i]) begin
                n_fail++; $display("FAIL chain_acc_%0d got=%0d want=%0d", i, acc_value, exp_v[i]);
            end
            if (i < 2) tick();
        end
        n_chk++;
        if (res_zero !== 1'b1) begin n_fail++; $display("FAIL chain_zero got=%b want=1", res_zero); end
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd2, 32'd100 * i, 32'd1 + i, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_chk += 2;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b want=0", cmd_ready); end
        if (res_valid !== 1'b1 || res_data !== 32'd1) begin
            n_fail++; $display("FAIL bp_first got=%b/%0d want=1/1", res_valid, res_data);
        end
        tick();
        n_chk++;
        if (res_data !== 32'd1) begin n_fail++; $display("FAIL bp_hold got=%0d want=1", res_data); end
        res_ready = 1;
        for (int i = 1; i < 5; i++) begin
            tick();
            n_chk++;
            if (res_valid !== 1'b1 || res_data !== 32'd101 * i + 1) begin
                n_fail++; $display("FAIL bp_drain_%0d got=%b/%0d want=1/%0d", i, res_valid, res_data, 101 * i + 1);
            end
        end
        tick();
        n_chk++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b want=0", res_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] expq[$];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        res_ready = 0;
        for (int i = 0; i < 13; i++) begin
            a = $urandom; b = $urandom;
            drive(1, 3'd3, a, b, 0);
            expq.push_back(a ^ b);
            if (i == 3) res_ready = 1;
            tick();
            if (m_iss) begin
                e = expq.pop_front();
                n_chk++;
                if (res_data !== e) begin n_fail++; $display("FAIL wrap_%0d got=%h want=%h", i, res_data, e); end
            end
        end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_iss) begin
                e = expq.pop_front();
                n_chk++;
                if (res_data !== e) begin n_fail++; $display("FAIL wrap_tail_%0d got=%h want=%h", i, res_data, e); end
            end
        end
        n_chk++;
        if (expq.size() != 0) begin n_fail++; $display("FAIL wrap_count got=%0d want=0", expq.size()); end
    endtask

    task automatic test_clear();
        res_ready = 1;
        drive(1, 3'd2, 32'd1, 32'd1, 0); tick();
        drive(1, 3'd2, 32'h5555, 32'd4, 1); acc_clear = 1; tick();
        drive(0, 0, 0, 0, 0); acc_clear = 0;
        n_chk += 2;
        if (res_data !== 32'd2) begin n_fail++; $display("FAIL clr_data got=%0d want=2", res_data); end
        if (acc_value !== '0)   begin n_fail++; $display("FAIL clr_acc got=%0d want=0", acc_value); end
        tick();
        n_chk += 2;
        if (res_data !== 32'd4)  begin n_fail++; $display("FAIL clr_next got=%0d want=4", res_data); end
        if (acc_value !== 32'd4) begin n_fail++; $display("FAIL clr_next_acc got=%0d want=4", acc_value); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ea;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom_range(0, 1) == 1);
            res_ready = $urandom_range(0, 9) < 7;
            acc_clear = $urandom_range(0, 15) == 0;
            rst       = $urandom_range(0, 99) == 0;
            tick();
            rst = 0; #1;
            n_chk += 4;
            if (res_valid !== m_rv || (m_rv && res_data !== m_rd)) begin
                n_fail++; $display("FAIL rnd_res_%0d got=%b/%h want=%b/%h", i, res_valid, res_data, m_rv, m_rd);
            end
            if (acc_value !== m_acc || res_zero !== (res_data == 0)) begin
                n_fail++; $display("FAIL rnd_acc_%0d got=%h/%b want=%h", i, acc_value, res_zero, m_acc);
            end
            if (cmd_ready !== (mq.size() < DEPTH)) begin
                n_fail++; $display("FAIL rnd_ready_%0d got=%b want=%b", i, cmd_ready, mq.size() < DEPTH);
            end
            ea = (mq.size() == 0) ? '0 : (mq[0].acc ? m_acc : mq[0].a);
            if (alu_A !== ea || alu_B !== ((mq.size() == 0) ? '0 : mq[0].b) ||
                alu_select !== ((mq.size() == 0) ? 3'd0 : mq[0].op)) begin
                n_fail++; $display("FAIL rnd_drive_%0d got=%h/%h/%h want_A=%h", i, alu_select, alu_A, alu_B, ea);
            end
        end
        drive(0, 0, 0, 0, 0); acc_clear = 0; res_ready = 1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        m_rv = 0; m_rd = '0; m_acc = '0; m_iss = 0;
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_wrap();
        test_clear();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
